barrel_shifter_seq: RTL and testbench
=====================================

BARREL_SHIFTER_SEQ -- requirements
Module: barrel_shifter_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request strobe; sampled only in IDLE.
REQ-005 Port: i  input  16  operand, captured on the accepting edge.
REQ-006 Port: s  input  4  shift amount 0..15, captured on the accepting edge.
REQ-007 Port: mode  input  2  operation: 00 logical right, 01 arithmetic right, 10 rotate right, 11 logical left; captured on the accepting edge.
REQ-008 Port: o  output  16  result register.
REQ-009 Port: busy  output  1  high while an operation is in progress (states S1..S8).
REQ-010 Port: done  output  1  single-cycle result-valid pulse.

Function
REQ-011 The FSM SHALL have the states IDLE, S1, S2, S4, S8 and DONE.
REQ-012 In IDLE with start=1 at edge N, the block SHALL capture i into an internal working register, capture s and mode, and move to S1.
REQ-013 S1, S2, S4 and S8 SHALL each last one cycle and SHALL apply a shift of 1, 2, 4 or 8 to the working register when s[0], s[1], s[2] or s[3] respectively is set; otherwise the stage SHALL pass the register through unchanged.
REQ-014 Stages SHALL advance in the fixed order S1→S2→S4→S8→DONE.
REQ-015 The working register SHALL be updated as each stage's edge leaves that stage.
REQ-016 At edge N+4 the final value SHALL be loaded into o, and the state SHALL become DONE.
REQ-017 done SHALL be 1 for exactly the cycle between edges N+4 and N+5; DONE SHALL then return to IDLE.
REQ-018 Latency SHALL be fixed at 4 cycles from the accepting edge to done for every s, including s=0.
REQ-019 busy SHALL be 1 from edge N+1 through edge N+4, and 0 in IDLE and DONE.
REQ-020 o SHALL hold its last result until the next DONE load; o SHALL NOT change during S1..S8.
REQ-021 Logical right shift SHALL fill with 0 at the MSB.
REQ-022 Arithmetic right shift SHALL fill with the captured i[15].
REQ-023 Rotate right SHALL feed the bits shifted out at the LSB back in at the MSB.
REQ-024 Logical left shift SHALL fill with 0 at the LSB.
REQ-025 All arithmetic SHALL be 16-bit, with no carry or overflow output.
REQ-026 start asserted in S1..S8 or DONE SHALL be ignored and not queued.
REQ-027 Changes on i, s or mode after the accepting edge SHALL NOT affect the operation in progress.
REQ-028 start held high continuously SHALL yield back-to-back operations with one accept every 6 cycles (IDLE→S1..S8→DONE→IDLE).

Reset
REQ-029 While rst=1 at a rising edge, the state SHALL become IDLE, and o, the working register, busy and done SHALL all become 0.
REQ-030 Reset SHALL take priority over start and over any stage advance.
REQ-031 Reset asserted mid-operation SHALL abort the operation, with no done pulse and o=0.
REQ-032 The first start after rst deasserts SHALL be accepted on the next edge at which rst=0.

Verification
REQ-033 i=16'hFFFF, s=0, mode=00, start pulse → done exactly 4 cycles after accept, o=16'hFFFF, busy high for 4 cycles.
REQ-034 i=16'hFFFF with mode=00 and s=1, 2, 4, 8 in turn → o=16'h7FFF, 16'h3FFF, 16'h0FFF, 16'h00FF respectively.
REQ-035 i=16'h8000, s=8, mode=01 → o=16'hFF80; then i=16'h8001, s=4, mode=10 → o=16'h1800; then i=16'h0001, s=15, mode=11 → o=16'h8000.
REQ-036 Accept i=16'h00F0, s=4, mode=00, then pulse start with i=16'hFFFF during S2 → a single done pulse, o=16'h000F, and no second operation.
REQ-037 Accept an operation, then assert rst for one cycle in S4 → no done pulse, o=0, busy=0; a new start on the next cycle is accepted normally.
REQ-038 start held high for 12 cycles after reset → exactly two done pulses, 6 cycles apart.

Source files
------------

// File: rtl/barrel_shifter_seq.sv
// Sequential barrel shifter: applies shifts of 1, 2, 4 and 8 in four fixed stages, so every
// operation takes exactly four cycles from accept to done regardless of the shift amount.
module barrel_shifter_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] i,
  input  logic [3:0]  s,
  input  logic [1:0]  mode,
  output logic [15:0] o,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StS1, StS2, StS4, StS8, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] o_q, o_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] stage_val;

  // One stage of the shifter: shift v by a fixed power-of-two amount k.
  function automatic logic [15:0] shift_by(input logic [15:0] v, input logic [1:0] m,
                                           input int unsigned k);
    unique case (m)
      2'b00:   return v >> k;
      2'b01:   return $signed(v) >>> k;
      2'b10:   return (v >> k) | (v << (16 - k));
      default: return v << k;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    o_d       = o_q;
    amt_d     = amt_q;
    mode_d    = mode_q;
    stage_val = work_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = i;
          amt_d   = s;
          mode_d  = mode;
          state_d = StS1;
        end
      end
      StS1: begin
        if (amt_q[0]) stage_val = shift_by(work_q, mode_q, 1);
        work_d  = stage_val;
        state_d = StS2;
      end
      StS2: begin
        if (amt_q[1]) stage_val = shift_by(work_q, mode_q, 2);
        work_d  = stage_val;
        state_d = StS4;
      end
      StS4: begin
        if (amt_q[2]) stage_val = shift_by(work_q, mode_q, 4);
        work_d  = stage_val;
        state_d = StS8;
      end
      StS8: begin
        if (amt_q[3]) stage_val = shift_by(work_q, mode_q, 8);
        work_d  = stage_val;
        o_d     = stage_val;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      o_q     <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      o_q     <= o_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
    end
  end

  assign o    = o_q;
  assign busy = (state_q == StS1) || (state_q == StS2) || (state_q == StS4) ||
                (state_q == StS8);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_barrel_shifter_seq.sv
// Self-checking bench for barrel_shifter_seq: directed cases plus randomized operations
// compared against a whole-word arithmetic reference model.
module tb_barrel_shifter_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] i = '0;
  logic [3:0]  s = '0;
  logic [1:0]  mode = '0;
  logic [15:0] o;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  barrel_shifter_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .i    (i),
    .s    (s),
    .mode (mode),
    .o    (o),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: the shift is done in one step on widened operands.
  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [3:0] k,
                                         input logic [1:0] m);
    logic [31:0] wide;
    case (m)
      2'b00:   return a >> k;
      2'b01:   begin wide = {{16{a[15]}}, a} >> k; return wide[15:0]; end
      2'b10:   begin wide = {a, a} >> k;           return wide[15:0]; end
      default: begin wide = {16'h0, a} << k;       return wide[15:0]; end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one operation starting at the next negedge; optionally pulses start during S2.
  task automatic do_op(input logic [15:0] ii, input logic [3:0] ss, input logic [1:0] mm,
                       input bit glitch);
    logic [15:0] o_prev;
    logic [15:0] exp;
    int lat;
    exp = ref_op(ii, ss, mm);
    @(negedge clk);
    o_prev = o;
    start = 1'b1; i = ii; s = ss; mode = mm;
    @(negedge clk);
    start = 1'b0;
    i = 16'($urandom); s = 4'($urandom); mode = 2'($urandom);
    lat = 0;
    while (!done && lat < 12) begin
      check_eq("busy_in_op", busy, 1'b1);
      check_eq("o_stable", o, o_prev);
      if (glitch && lat == 1) begin
        start = 1'b1; i = 16'hFFFF;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check_eq("done_seen", done, 1'b1);
    check_eq("latency", lat, 4);
    check_eq("result", o, exp);
    check_eq("busy_in_done", busy, 1'b0);
    @(negedge clk);
    check_eq("done_single", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
    if (glitch) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check_eq("no_queued_op", {busy, done}, 2'b00);
      end
    end
  endtask

  initial begin
    logic [15:0] exp_vals [4];
    int done_cyc [$];

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_o", o, 16'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);

    do_op(16'hFFFF, 4'd0, 2'b00, 1'b0);

    exp_vals = '{16'h7FFF, 16'h3FFF, 16'h0FFF, 16'h00FF};
    for (int k = 0; k < 4; k++) begin
      do_op(16'hFFFF, 4'(1 << k), 2'b00, 1'b0);
      check_eq("lsr_const", o, exp_vals[k]);
    end

    do_op(16'h8000, 4'd8, 2'b01, 1'b0);
    check_eq("asr_const", o, 16'hFF80);
    do_op(16'h8001, 4'd4, 2'b10, 1'b0);
    check_eq("ror_const", o, 16'h1800);
    do_op(16'h0001, 4'd15, 2'b11, 1'b0);
    check_eq("lsl_const", o, 16'h8000);

    // start during S2 must be ignored
    do_op(16'h00F0, 4'd4, 2'b00, 1'b1);
    check_eq("ignored_start", o, 16'h000F);

    // Reset in S4 aborts the operation
    @(negedge clk);
    start = 1'b1; i = 16'h1234; s = 4'd3; mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_o", o, 16'h0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    do_op(16'hA5A5, 4'd5, 2'b10, 1'b0);

    // start held high for 12 cycles after reset
    do_reset();
    start = 1'b1; i = 16'h0F0F; s = 4'd2; mode = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) done_cyc.push_back(c);
    end
    start = 1'b0;
    check_eq("held_pulses", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check_eq("held_spacing", done_cyc[1] - done_cyc[0], 6);
    check_eq("held_result", o, 16'h03C3);
    repeat (8) @(negedge clk);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op(16'($urandom), 4'($urandom), 2'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
